// File: rtl/pipelined_chunk_adder.sv
// Pipelined WIDTH-bit add/subtract built from CHUNK-bit ripple slices, one slice
// per stage, with a valid/ready handshake and full-pipeline backpressure.
module pipelined_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = WIDTH / CHUNK;

  // Each stage carries the full operand words; only the chunks not yet consumed
  // (and the two MSBs for overflow) matter downstream, the rest trims away.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
  } stage_t;

  stage_t in_stage;
  stage_t pipe_d [STAGES];
  stage_t pipe_q [STAGES];
  logic   ovf_d;
  logic   ovf_q;
  logic   adv;

  // A single global advance: the whole pipe moves or the whole pipe holds.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    in_stage       = '0;
    in_stage.valid = in_valid;
    in_stage.a     = in_a;
    in_stage.b     = in_sub ? ~in_b : in_b;
    in_stage.carry = in_sub ? 1'b1 : in_cin;
  end

  // NOTE: every variable gets a full default assignment before any partial
  // update, so no path through this block can infer a latch.
  always_comb begin
    logic c;
    logic bit_a;
    logic bit_b;
    pipe_d[0] = in_stage;
    for (int k = 1; k < STAGES; k++) pipe_d[k] = pipe_q[k-1];
    for (int k = 0; k < STAGES; k++) begin
      c = pipe_d[k].carry;
      for (int i = 0; i < CHUNK; i++) begin
        bit_a = pipe_d[k].a[k*CHUNK+i];
        bit_b = pipe_d[k].b[k*CHUNK+i];
        pipe_d[k].sum[k*CHUNK+i] = bit_a ^ bit_b ^ c;
        c = (bit_a & bit_b) | (c & (bit_a ^ bit_b));
      end
      pipe_d[k].carry = c;
    end
  end

  // Signed overflow: operands agree in sign but the result does not.
  always_comb begin
    ovf_d = (pipe_d[STAGES-1].a[WIDTH-1] == pipe_d[STAGES-1].b[WIDTH-1]) &&
            (pipe_d[STAGES-1].sum[WIDTH-1] != pipe_d[STAGES-1].a[WIDTH-1]);
  end

  // NOTE: the stage registers are ordinary flops, not a RAM, so clearing them
  // on reset is cheap and guarantees no stale result survives a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      // NOTE: non-blocking assignments so every stage samples its
      // predecessor's pre-edge value and data shifts exactly one stage.
      for (int k = 0; k < STAGES; k++) pipe_q[k] <= pipe_d[k];
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = pipe_q[STAGES-1].valid;
  assign out_sum   = pipe_q[STAGES-1].sum;
  assign out_cout  = pipe_q[STAGES-1].carry;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pipelined_chunk_adder.sv
// Directed self-checking bench for pipelined_chunk_adder at default parameters:
// single ops, streaming, backpressure and mid-flight reset.
module tb_pipelined_chunk_adder;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int STAGES = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  int tests = 0;
  int fails = 0;

  pipelined_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Golden model: {ovf, cout, sum} from a plain wide addition.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    logic             ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, (sub ? 1'b1 : cin)};
    ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != a[WIDTH-1]);
    return {ovf, full};
  endfunction

  task automatic do_single(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic cin, input logic sub, input logic [WIDTH-1:0] exp_sum,
                           input logic exp_cout, input logic exp_ovf);
    in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_valid = 1'b1;
    #1;
    check({tag, " in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < STAGES - 1; i++) begin
      check($sformatf("%s early valid %0d", tag, i), out_valid, 0);
      tick();
    end
    check({tag, " valid"}, out_valid, 1);
    check({tag, " sum"}, out_sum, exp_sum);
    check({tag, " cout"}, out_cout, exp_cout);
    check({tag, " ovf"}, out_ovf, exp_ovf);
    tick();
    check({tag, " valid one cycle"}, out_valid, 0);
  endtask

  logic [WIDTH-1:0] op_a   [8];
  logic [WIDTH-1:0] op_b   [8];
  logic             op_cin [8];
  logic             op_sub [8];
  logic [WIDTH+1:0] exp_v;
  logic [WIDTH-1:0] held;

  initial begin
    int si;
    int ri;
    int hold;
    bit stalled_once;
    bit acc;
    bit emit;

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    out_ready = 1'b1;
    #2;
    check("reset out_valid", out_valid, 0);
    check("reset out_sum", out_sum, 0);
    check("reset out_cout", out_cout, 0);
    check("reset out_ovf", out_ovf, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post-reset in_ready", in_ready, 1);

    // Directed single operations with hand-computed results.
    do_single("add 1234+4321", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_single("add ffff+0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    do_single("add 7fff+0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_single("add 00ff+0+cin", 16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0);
    do_single("sub 0005-0007", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    do_single("sub 8000-0001 cin ignored", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream of 8 operations.
    op_a   = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'hABCD, 16'h0F0F, 16'h5A5A};
    op_b   = '{16'h0002, 16'hFFFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h1111, 16'hF0F0, 16'hA5A5};
    op_cin = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    op_sub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    ri = 0;
    out_ready = 1'b1;
    for (int t = 0; t < 8 + STAGES + 1; t++) begin
      if (t < 8) begin
        in_valid = 1'b1; in_a = op_a[t]; in_b = op_b[t]; in_cin = op_cin[t]; in_sub = op_sub[t];
        #1;
        check($sformatf("stream in_ready %0d", t), in_ready, 1);
      end else begin
        in_valid = 1'b0;
      end
      tick();
      check($sformatf("stream valid t%0d", t), out_valid,
            {31'd0, (t >= STAGES - 1) && (t < STAGES - 1 + 8)});
      if (out_valid && ri < 8) begin
        exp_v = model(op_a[ri], op_b[ri], op_cin[ri], op_sub[ri]);
        check($sformatf("stream result %0d", ri), {out_ovf, out_cout, out_sum}, exp_v);
        ri++;
      end
    end
    check("stream result count", ri, 8);

    // Backpressure: 6 operations, 5-cycle stall once the first result shows.
    si = 0; ri = 0; hold = 0; stalled_once = 1'b0;
    for (int t = 0; t < 60 && !(si == 6 && ri == 6); t++) begin
      if (out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        hold = 5;
        held = out_sum;
      end
      out_ready = (hold == 0);
      in_valid = (si < 6);
      if (si < 6) begin
        in_a = op_a[si]; in_b = op_b[si]; in_cin = op_cin[si]; in_sub = op_sub[si];
      end
      #1;
      if (hold > 0) begin
        check($sformatf("stall in_ready h%0d", hold), in_ready, 0);
        check($sformatf("stall out_valid h%0d", hold), out_valid, 1);
        check($sformatf("stall sum held h%0d", hold), out_sum, held);
        hold--;
      end
      acc  = in_valid && in_ready;
      emit = out_valid && out_ready;
      if (emit) begin
        if (ri < 6) begin
          exp_v = model(op_a[ri], op_b[ri], op_cin[ri], op_sub[ri]);
          check($sformatf("bp result %0d", ri), {out_ovf, out_cout, out_sum}, exp_v);
        end
        ri++;
      end
      if (acc) si++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("bp stall happened", stalled_once, 1);
    check("bp results count", ri, 6);
    check("bp accepted count", si, 6);
    repeat (STAGES) begin
      check("bp no extra result", out_valid, 0);
      tick();
    end

    // Reset with operations in flight.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_a = 16'h1111 * (i + 1); in_b = 16'h0101; in_cin = 1'b0; in_sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1);
    check("pre-reset out_sum", out_sum, 16'h1212);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset out_valid", out_valid, 0);
    check("async reset out_sum", out_sum, 0);
    check("async reset out_cout", out_cout, 0);
    tick();
    rst_n = 1'b1;
    tick();
    do_single("after reset 1+1", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
